// File: rtl/feature_vector_assembler.sv
// Serial-to-parallel assembler for the logistic-regression feature vector.
// Slot 0 carries the bias constant; slots 1..N_FEAT fill from the sample stream.

module fva_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module feature_vector_assembler #(
    parameter int          N_FEAT   = 40,
    parameter int          W        = 32,
    parameter logic [W-1:0] BIAS_VAL = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] xarray [0:N_FEAT],
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err,
    output logic [15:0]  vec_count
);
    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] idx;
    logic          ferr_q;
    logic [15:0]   vec_cnt_q;

    logic accept, deliver, at_end;

    // in_ready looks through to out_ready so a full vector can hand off
    // and the first sample of the next one land on the same edge
    assign in_ready  = !clear && (state == S_FILL || out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = !clear && (state == S_FULL) && out_ready;
    assign at_end    = (idx == IW'(N_FEAT - 1));

    assign out_valid = (state == S_FULL);
    assign frame_err = ferr_q;
    assign vec_count = vec_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            idx       <= '0;
            ferr_q    <= 1'b0;
            vec_cnt_q <= '0;
        end else if (clear) begin
            state  <= S_FILL;
            idx    <= '0;
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (deliver) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
                state     <= S_FILL;
            end
            if (accept) begin
                if (in_last && at_end) begin
                    idx   <= '0;
                    state <= S_FULL;
                end else if (in_last || at_end) begin
                    // framing error: drop the partial vector and restart
                    idx    <= '0;
                    ferr_q <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign xarray[0] = BIAS_VAL;

    for (genvar k = 1; k <= N_FEAT; k++) begin : g_slot
        fva_slot #(.W(W)) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (accept && (idx == IW'(k - 1))),
            .d    (in_data),
            .q    (xarray[k])
        );
    end
endmodule

// File: doc/feature_vector_assembler.md
# feature_vector_assembler

Collects a serial stream of 32-bit feature samples into the 41-entry feature vector consumed by the `innerproduct` logistic-regression scorers, and presents it with a valid/ready handshake. Slot 0 is the bias slot and holds a constant. Slots 1..40 are filled positionally from the stream. The block sits between the line buffer / pixel-stream front end and the combinational inner-product stage, so the scorer always sees a stable, complete vector while `out_valid` is high.

## Interface
- `N_FEAT`, default 40: features per vector, filling slots 1..N_FEAT.
- `W`, default 32: sample and slot width.
- `BIAS_VAL`, default 32'd1: constant driven on slot 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `clear`  in  1  synchronous restart of the current vector.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  W  feature sample.
- `in_last`  in  1  marks the final sample of a vector.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `xarray`  out  W x (N_FEAT+1)  unpacked `[0:N_FEAT]`, registered feature vector.
- `out_valid`  out  1  `xarray` is complete and stable.
- `out_ready`  in  1  the consumer takes the vector this cycle.
- `frame_err`  out  1  one-cycle pulse on a framing error.
- `vec_count`  out  16  number of vectors delivered; wraps at 16'hFFFF -> 0.

## Operation
- **States:**
  - FILL: accepting samples.
  - FULL: vector held, `out_valid`=1.
- **Counter:** `idx`, range 0..N_FEAT-1, is the index of the next sample.
- **Accepted sample:** when `in_valid && in_ready`:
  - `in_data` is written to `xarray[idx+1]`.
  - `idx` increments.
- **Completion:** when the sample accepted at `idx`=N_FEAT-1 has `in_last`=1:
  - `idx` returns to 0.
  - State goes to FULL.
- **Framing errors:**
  - Case 1: `in_last`=1 at `idx` < N_FEAT-1.
  - Case 2: `in_last`=0 at `idx`=N_FEAT-1.
  - The offending sample is still written to its slot.
  - `frame_err` pulses the next cycle.
  - `idx` returns to 0 and the state stays FILL. The partial vector is discarded and never presented.
- **Slot 0:** `xarray[0]` is always BIAS_VAL, combinational from the parameter, not a register.
- **In FULL:**
  - `xarray[1..N_FEAT]` are frozen.
  - On `out_ready`=1, the vector is delivered and `vec_count` increments.
  - The state returns to FILL the next cycle.
- **`in_ready` rule:** `in_ready = !clear && (state==FILL || out_ready)`.
  - This is combinational from `out_ready`.
  - In FULL with `out_ready`=1, a simultaneous input sample is accepted into `xarray[1]` with `idx`→1, and the state goes to FILL.
  - The consumer samples the old vector at that same edge.
- **Slot contents while filling:** during FILL, slots not yet written this vector retain their previous values. `out_valid`=0 marks them as don't-care.
- **`clear`:**
  - Next state is FILL, `idx`=0, and `out_valid` goes to 0.
  - No input is accepted and no vector is delivered in that cycle.
  - Slots are not zeroed and `vec_count` is unchanged.
  - `clear` has priority over every other event.
- **Arithmetic:** no arithmetic on data; samples are copied bit-exact.

## Timing
- **Reset values (rst_n=0), asynchronous:**
  - State FILL, `idx`=0.
  - `xarray[1..N_FEAT]`=0.
  - `out_valid`=0, `frame_err`=0, `vec_count`=0.
  - `in_ready`=1, provided `clear`=0.
- **Reset mid-vector:** the partial vector is lost; no `frame_err`.
- **Latency:** `out_valid` rises the cycle after the edge that accepted the final sample.
- **Minimum vector period:** N_FEAT cycles, achieved with `out_ready` tied high and `in_valid` continuous.
- **Bubbles:** `in_valid` gaps are allowed anywhere and do not affect `idx`.
- **Output stability:** `xarray` and `out_valid` are stable from the rise of `out_valid` until the handshake edge.
- **Back-pressure:** while FULL with `out_ready`=0, `in_ready`=0 and the stream stalls.
- **`frame_err`:** exactly one cycle per error; back-to-back errors give back-to-back pulses.

## Test plan
- **Basic fill:**
  - Stimulus: after reset, feed 40 samples 1..40, `in_last` on the 40th, `out_ready`=0.
  - Response: `out_valid`=1 one cycle after the 40th; `xarray[0]`=1, `xarray[k]`=k; `in_ready`=0.
  - Then assert `out_ready` for 1 cycle: `vec_count`=1 and `out_valid`=0 next cycle.
- **Streaming:**
  - Stimulus: `out_ready`=1, continuous 400 samples forming 10 vectors (sample value = 100·v+k).
  - Response: 10 `out_valid` pulses spaced 40 cycles apart; `vec_count`=10.
  - No stall; `xarray[1]` of vector 2 equals 201 after the overlap edge.
- **Early last:**
  - Stimulus: `in_last` on sample 5.
  - Response: `frame_err` pulse, no `out_valid`.
  - A following clean 40-sample vector is delivered correctly.
- **Missing last:**
  - Stimulus: 40 samples with `in_last`=0.
  - Response: `frame_err` pulse, `idx` back to 0, no `out_valid`.
- **Clear and reset mid-operation:**
  - Stimulus: `clear` with a valid sample at sample 20.
  - Response: that sample is not accepted (`in_ready`=0); the next 40-sample vector completes.
  - Stimulus: `rst_n` pulsed low while FULL.
  - Response: immediately `out_valid`=0, `vec_count`=0, `xarray[1..40]`=0.
- **Counter wrap:**
  - Stimulus: force `vec_count`=16'hFFFF, then deliver 1 vector.
  - Response: `vec_count`=0.
